spm_dp: RTL and testbench

- Parametrised dual-port scratchpad memory (SPM) for the CPU core.
- Port A serves instruction fetch (IF stage); port B serves load/store (MEM stage).
- Generalises the fixed 4096x32 SPM with:
  - configurable width and depth;
  - per-byte write enables;
  - defined same-address collision and read-during-write semantics;
  - an optional post-reset clear sequencer with a busy flag.

---
 rtl/spm_port_if.sv | 34 +++
 rtl/spm_dp.sv | 84 ++++++++
 tb/tb_spm_dp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spm_port_if.sv
// One SPM access port: word address, active-low strobe, direction, byte enables,
// write data and the registered read data returned one clock later.
interface spm_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    // Handshake: an access is taken on every clock edge where as_ = 0 and the
    // memory is not busy; there is no ready/stall, and rd_data is valid one
    // edge after a taken access and holds until the next taken access.
    logic [ADDR_W-1:0]   addr;
    logic                as_;
    logic                rw;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;

    modport master (
        output addr,
        output as_,
        output rw,
        output be,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  as_,
        input  rw,
        input  be,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/spm_dp.sv
// Dual-port scratchpad: port A for instruction fetch, port B for load/store,
// byte-masked write-first access and an optional post-reset zeroing pass.
module spm_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       busy,
    spm_port_if.slave  a,
    spm_port_if.slave  b,
    output logic       coll
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_val, b_val, a_wen, b_wen, same;
    logic [DATA_W-1:0]   a_word, b_word, a_merge, b_merge;

    assign busy   = (state == CLEAR);
    assign a_val  = !busy && !a.as_;
    assign b_val  = !busy && !b.as_;
    assign a_wen  = a_val && !a.rw;
    assign b_wen  = b_val && !b.rw;
    assign same   = (a.addr == b.addr);
    assign a_word = mem[a.addr];
    assign b_word = mem[b.addr];

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && cnt == ADDR_W'(DEPTH - 1)) begin
            state_nxt = READY;
        end
    end

    // Both merges resolve a same-address write pair identically (B wins per byte),
    // so each port's view is the final post-edge word.
    always_comb begin
        a_merge = a_word;
        b_merge = b_word;
        for (int i = 0; i < NB; i++) begin
            if (a_wen && a.be[i])         a_merge[8*i +: 8] = a.wr_data[8*i +: 8];
            if (b_wen && same && b.be[i]) a_merge[8*i +: 8] = b.wr_data[8*i +: 8];
            if (a_wen && same && a.be[i]) b_merge[8*i +: 8] = a.wr_data[8*i +: 8];
            if (b_wen && b.be[i])         b_merge[8*i +: 8] = b.wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else begin
            if (a_wen) mem[a.addr] <= a_merge;
            if (b_wen) mem[b.addr] <= b_merge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt       <= '0;
            a.rd_data <= '0;
            b.rd_data <= '0;
            coll      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) cnt <= cnt + 1'b1;
            if (a_val) a.rd_data <= a_merge;
            if (b_val) b.rd_data <= b_merge;
            coll <= a_wen && b_wen && same && (|(a.be & b.be));
        end
    end
endmodule

// File: tb/tb_spm_dp.sv
// Directed bench for spm_dp (32-bit x 16 words, clear on reset) with a
// per-cycle scoreboard of expected read data and collision flag.
module tb_spm_dp;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk;
    logic reset;
    logic busy;
    logic coll;

    spm_port_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
    spm_port_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

    spm_dp #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .busy  (busy),
        .a     (a_if),
        .b     (b_if),
        .coll  (coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    logic [DW-1:0] exp_c_q[$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drv_a(input logic as_, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
        a_if.as_ = as_; a_if.rw = rw; a_if.addr = addr; a_if.be = be; a_if.wr_data = wd;
    endtask

    task automatic drv_b(input logic as_, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wd);
        b_if.as_ = as_; b_if.rw = rw; b_if.addr = addr; b_if.be = be; b_if.wr_data = wd;
    endtask

    task automatic idle();
        drv_a(1'b1, 1'b1, '0, '0, '0);
        drv_b(1'b1, 1'b1, '0, '0, '0);
    endtask

    // Push what the outputs must show after the next edge, clock, then pop and compare.
    task automatic cycle(input string tag, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                         input logic ec);
        logic [DW-1:0] qa, qb, qc;
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        exp_c_q.push_back({{(DW-1){1'b0}}, ec});
        last_a = ea;
        last_b = eb;
        @(posedge clk);
        #1;
        qa = exp_a_q.pop_front();
        qb = exp_b_q.pop_front();
        qc = exp_c_q.pop_front();
        check({tag, "_a_rd"}, a_if.rd_data, qa);
        check({tag, "_b_rd"}, b_if.rd_data, qb);
        check({tag, "_coll"}, {{(DW-1){1'b0}}, coll}, qc);
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            cycle(tag, 32'h0, 32'h0, 1'b0);
            n++;
        end
        check({tag, "_busy_cycles"}, DW'(n), DW'(16));
        check({tag, "_busy_low"}, {{(DW-1){1'b0}}, busy}, '0);
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            drv_a(1'b0, 1'b1, AW'(i), '0, '0);
            drv_b(1'b0, 1'b1, AW'(15 - i), '0, '0);
            cycle(tag, 32'h0, 32'h0, 1'b0);
        end
        idle();
    endtask

    initial begin
        logic [DW-1:0] ga, gb;
        reset = 1'b0;
        idle();
        #1 reset = 1'b1;
        #1;
        check("rst_busy", {{(DW-1){1'b0}}, busy}, DW'(1));
        check("rst_a_rd", a_if.rd_data, '0);
        check("rst_b_rd", b_if.rd_data, '0);
        check("rst_coll", {{(DW-1){1'b0}}, coll}, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Accesses while clearing must be ignored: rd_data stays 0, memory untouched.
        drv_a(1'b0, 1'b0, 4'd1, 4'hF, 32'hFFFF_FFFF);
        drv_b(1'b0, 1'b1, 4'd1, 4'h0, 32'h0);
        wait_clear("clear1");
        idle();
        read_all_zero("zero1");

        // Fill every word with nonzero garbage.
        for (int i = 0; i < 8; i++) begin
            ga = $urandom() | 32'h1;
            gb = $urandom() | 32'h1;
            drv_a(1'b0, 1'b0, AW'(i), 4'hF, ga);
            drv_b(1'b0, 1'b0, AW'(i + 8), 4'hF, gb);
            cycle("garbage", ga, gb, 1'b0);
        end
        idle();

        // Reset, let the clear reach count 9, then reset again: clear must restart.
        reset = 1'b1;
        #1;
        check("rst2_a_rd", a_if.rd_data, '0);
        check("rst2_busy", {{(DW-1){1'b0}}, busy}, DW'(1));
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 9; i++) cycle("partial", 32'h0, 32'h0, 1'b0);
        check("mid_busy", {{(DW-1){1'b0}}, busy}, DW'(1));
        reset = 1'b1;
        #1;
        check("rst3_busy", {{(DW-1){1'b0}}, busy}, DW'(1));
        @(posedge clk);
        #1 reset = 1'b0;
        wait_clear("clear2");
        read_all_zero("zero2");

        // Byte-masked write then read.
        drv_b(1'b0, 1'b0, 4'd5, 4'hF, 32'hDEAD_BEEF);
        cycle("bwr_full", last_a, 32'hDEAD_BEEF, 1'b0);
        drv_b(1'b0, 1'b0, 4'd5, 4'h1, 32'h0000_00AA);
        cycle("bwr_byte0", last_a, 32'hDEAD_BEAA, 1'b0);
        idle();
        drv_a(1'b0, 1'b1, 4'd5, 4'h0, 32'h0);
        cycle("ard5", 32'hDEAD_BEAA, last_b, 1'b0);

        // Write-write collision, B wins on overlapping bytes.
        drv_a(1'b0, 1'b0, 4'd7, 4'hF, 32'h1111_1111);
        drv_b(1'b0, 1'b0, 4'd7, 4'h3, 32'h2222_2222);
        cycle("coll7", 32'h1111_2222, 32'h1111_2222, 1'b1);
        idle();
        cycle("coll7_after", last_a, last_b, 1'b0);
        drv_a(1'b0, 1'b1, 4'd7, 4'h0, 32'h0);
        cycle("ard7", 32'h1111_2222, last_b, 1'b0);

        // Read-during-write across ports returns the new word.
        drv_a(1'b0, 1'b1, 4'd3, 4'h0, 32'h0);
        drv_b(1'b0, 1'b0, 4'd3, 4'hF, 32'h1234_5678);
        cycle("rdw3", 32'h1234_5678, 32'h1234_5678, 1'b0);

        // Same-address writes with disjoint masks: merged, no collision flag.
        drv_a(1'b0, 1'b0, 4'd9, 4'hC, 32'hAABB_CCDD);
        drv_b(1'b0, 1'b0, 4'd9, 4'h3, 32'h1122_3344);
        cycle("disjoint9", 32'hAABB_3344, 32'hAABB_3344, 1'b0);
        idle();

        // be = 0 write leaves memory unchanged and returns the current word.
        drv_a(1'b0, 1'b0, 4'd5, 4'h0, 32'hFFFF_FFFF);
        cycle("be0_wr5", 32'hDEAD_BEAA, last_b, 1'b0);
        idle();
        drv_b(1'b0, 1'b1, 4'd5, 4'h0, 32'h0);
        cycle("brd5", last_a, 32'hDEAD_BEAA, 1'b0);

        // Top address.
        drv_b(1'b0, 1'b0, 4'd15, 4'hF, 32'h0F0F_0F0F);
        cycle("bwr15", last_a, 32'h0F0F_0F0F, 1'b0);
        idle();
        drv_a(1'b0, 1'b1, 4'd15, 4'h0, 32'h0);
        cycle("ard15", 32'h0F0F_0F0F, last_b, 1'b0);

        // Hold behaviour with strobe deasserted.
        idle();
        drv_b(1'b0, 1'b0, 4'd2, 4'hF, 32'hCAFE_F00D);
        cycle("bwr2", last_a, 32'hCAFE_F00D, 1'b0);
        idle();
        drv_a(1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        cycle("ard2", 32'hCAFE_F00D, last_b, 1'b0);
        drv_a(1'b1, 1'b0, 4'd2, 4'hF, 32'h0);
        cycle("hold1", 32'hCAFE_F00D, last_b, 1'b0);
        drv_a(1'b1, 1'b1, 4'd5, 4'h0, 32'h0);
        cycle("hold2", 32'hCAFE_F00D, last_b, 1'b0);
        drv_a(1'b1, 1'b0, 4'd2, 4'hF, 32'h5555_5555);
        cycle("hold3", 32'hCAFE_F00D, last_b, 1'b0);
        idle();
        drv_b(1'b0, 1'b1, 4'd2, 4'h0, 32'h0);
        cycle("brd2", last_a, 32'hCAFE_F00D, 1'b0);
        drv_b(1'b0, 1'b1, 4'd1, 4'h0, 32'h0);
        cycle("brd1", last_a, 32'h0, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
